// File: rtl/sram_node_pkg.sv
// Shared defaults and node word layout for the sram-backed node queue.
// Queue logic treats node words as opaque data.
package sram_node_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 34;
  localparam int DEF_DEPTH      = 8;

  typedef struct packed {
    logic [11:0] hi_ptr;
    logic [11:0] lo_ptr;
    logic [9:0]  var_idx;
  } node_t;

endpackage

// File: rtl/sram_node_obuf.sv
// Two-entry register FIFO that absorbs sram read data.
// Head is always entry 0, so out_data comes straight from a register.
module sram_node_obuf
  import sram_node_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = push_data;
          else               ent1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; shift when both slots are live
          if (cnt_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;

endmodule

// File: rtl/sram_node_queue.sv
// FIFO controller over an external dual-port sram (A write, B read).
// A 2-entry output buffer hides the 1-cycle read latency.
module sram_node_queue
  import sram_node_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sram_data_a,
  output logic [ADDR_WIDTH-1:0] sram_addr_a,
  output logic                  sram_we_a,
  output logic [ADDR_WIDTH-1:0] sram_addr_b,
  input  logic [DATA_WIDTH-1:0] sram_q_b,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] stored;
  logic [1:0]    ocnt;
  logic          push, pop, issue;

  assign stored   = wr_ptr_q - rd_ptr_q;
  assign in_ready = !rst && !flush && (stored != FULL);
  assign push     = in_valid && in_ready;
  assign out_valid = (ocnt != 2'd0);
  assign pop      = out_valid && out_ready;

  // Room check counts buffered, in-flight and the word leaving this cycle
  assign issue = (stored != '0) && !flush &&
                 (({1'b0, ocnt} + {2'b00, inflight_q}) <
                  (3'd2 + {2'b00, pop}));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  sram_node_obuf #(
    .W(DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (inflight_q && !flush),
    .push_data (sram_q_b),
    .pop       (pop),
    .head      (out_data),
    .count     (ocnt)
  );

  assign sram_we_a   = push;
  assign sram_data_a = in_data;
  assign sram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
  assign sram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];

  assign level = LW'(stored) + LW'(inflight_q) + LW'(ocnt);

endmodule

// File: tb/tb_sram_node_queue.sv
// Scoreboard bench for sram_node_queue with a behavioural sram model.
// Reference model: a plain queue of words held, popped in push order.
module tb_sram_node_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [33:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] sram_data_a;
  logic [2:0]  sram_addr_a;
  logic        sram_we_a;
  logic [2:0]  sram_addr_b;
  logic [33:0] sram_q_b;
  logic [4:0]  level;

  sram_node_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sram_data_a (sram_data_a),
    .sram_addr_a (sram_addr_a),
    .sram_we_a   (sram_we_a),
    .sram_addr_b (sram_addr_b),
    .sram_q_b    (sram_q_b),
    .level       (level)
  );

  logic [33:0] mem [8];

  always @(posedge clk) begin
    if (sram_we_a) mem[sram_addr_a] <= sram_data_a;
    sram_q_b <= mem[sram_addr_b];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [33:0] exp_q [$];
  int          push_cycles [$];
  int          pop_cycles [$];
  bit          bound_chk = 0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples 1 time unit before each rising edge
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
        exp_q.delete();
      end else begin
        check("level", 64'(level), 64'(exp_q.size()));
        if (bound_chk) begin
          check("level_le_10", 64'(level <= 5'd10), 64'd1);
          if (sram_we_a) begin
            check("we_needs_room", 64'(exp_q.size() <= 9), 64'd1);
            check("we_needs_valid", 64'(in_valid), 64'd1);
          end
        end
        if (out_valid && out_ready) begin
          check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0)
            check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
          pop_cycles.push_back(cyc);
        end
        if (flush) exp_q.delete();
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          push_cycles.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk)
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [33:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #3;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("push_accept", 64'(in_ready), 64'd1);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = '0;
    out_ready = 1'b0;
    #13;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_we", 64'(sram_we_a), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1: single word latency
    out_ready = 1'b1;
    push_cycles.delete();
    pop_cycles.delete();
    push_word(34'h3_0000_0001);
    drain(20);
    check("t1_pops", 64'(pop_cycles.size()), 64'd1);
    if (pop_cycles.size() == 1 && push_cycles.size() == 1)
      check("t1_latency", 64'(pop_cycles[0] - push_cycles[0]), 64'd3);

    // 2: fill with consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push_word(34'(i));
    @(negedge clk);
    in_data = 34'd11;
    #3;
    check("t2_full_ready", 64'(in_ready), 64'd0);
    check("t2_full_level", 64'(level), 64'd10);
    drain(40);

    // 3: streaming at one word per cycle
    @(negedge clk);
    push_cycles.delete();
    pop_cycles.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) push_word(34'h1_0000_0000 + 34'(i));
    drain(40);
    check("t3_pop_count", 64'(pop_cycles.size()), 64'd40);
    check("t3_push_span", 64'(push_cycles[$] - push_cycles[0]), 64'd39);
    if (pop_cycles.size() == 40) begin
      check("t3_first_lat", 64'(pop_cycles[0] - push_cycles[0]), 64'd3);
      check("t3_no_gaps", 64'(pop_cycles[39] - pop_cycles[0]), 64'd39);
    end

    // 4: random backpressure
    bound_chk = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      push_word({2'($urandom_range(0, 3)), 32'($urandom)});
    end
    rand_ready = 1'b0;
    drain(60);
    bound_chk = 1'b0;

    // 5: flush with a read in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(34'h200 + 34'(i));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b1;
    #3;
    check("t5_pre_level", 64'(level), 64'd6);
    @(negedge clk);
    flush = 1'b0;
    #3;
    check("t5_level", 64'(level), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #3;
    check("t5_drop_ret", 64'(out_valid), 64'd0);
    push_word(34'h2A);
    drain(20);

    // 6: async reset between edges
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(34'h3_0000 + 34'(i));
    @(negedge clk);
    rand_ready = 1'b0;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd0);
    check("t6_we", 64'(sram_we_a), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    push_cycles.delete();
    pop_cycles.delete();
    push_word(34'h1111);
    push_word(34'h2222);
    push_word(34'h3333);
    drain(20);
    check("t6_pops", 64'(pop_cycles.size()), 64'd3);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
